// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_queue
//  Description : Dual-issue circular result queue between the exec pipes and
//                the register-file writeback ports (2 in / 2 out per cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_queue #(
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 3,
    parameter int STALL_SLACK = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             execWbA_i,
    input  logic             execWbB_i,
    input  logic [4:0]       execAddrA_i,
    input  logic [4:0]       execAddrB_i,
    input  logic [15:0]      execValA_i,
    input  logic [15:0]      execValB_i,
    input  logic [1:0]       execStatusA_i,
    input  logic [1:0]       execStatusB_i,
    output logic             wbA_o,
    output logic             wbB_o,
    output logic [4:0]       wbAddrA_o,
    output logic [4:0]       wbAddrB_o,
    output logic [15:0]      wbValA_o,
    output logic [15:0]      wbValB_o,
    output logic [1:0]       operationStatusA_o,
    output logic [1:0]       operationStatusB_o,
    output logic             stall_o,
    output logic [PTR_W:0]   count_o,
    output logic             overflow_o
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] STALL_LVL  = CNT_W'(DEPTH - STALL_SLACK);
    localparam logic [CNT_W:0]   ROOM_DEPTH = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W:0]   ROOM_ONE   = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   ROOM_TWO   = (CNT_W + 1)'(2);

    logic [4:0]       addr_mem_q   [DEPTH];
    logic [15:0]      val_mem_q    [DEPTH];
    logic [1:0]       status_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_q, rd_d, rd_nxt;
    logic [PTR_W-1:0] wr_q, wr_d, wr_b;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, stall_d;
    logic             overflow_q, overflow_d;

    logic             wbA_q, wbB_q;
    logic [4:0]       wbAddrA_q, wbAddrB_q;
    logic [15:0]      wbValA_q, wbValB_q;
    logic [1:0]       statusA_q, statusB_q;

    logic             pop_a, pop_b, acc_a, acc_b;
    logic [1:0]       pops;
    logic [CNT_W:0]   room;

    always_comb begin
        rd_nxt = rd_q + PTR_W'(1);
        // Pop decisions look only at stored entries; same-register pairs split.
        pop_a  = (count_q != '0);
        pop_b  = (count_q >= CNT_TWO) && (addr_mem_q[rd_q] != addr_mem_q[rd_nxt]);
        pops   = {1'b0, pop_a} + {1'b0, pop_b};

        // Entries leaving this edge free space for entries arriving this edge.
        room   = ROOM_DEPTH - {1'b0, count_q} + (CNT_W + 1)'(pops);
        acc_a  = execWbA_i && (room >= ROOM_ONE);
        acc_b  = execWbB_i && (room >= (acc_a ? ROOM_TWO : ROOM_ONE));

        wr_b   = wr_q + PTR_W'(acc_a);
        wr_d   = wr_q + PTR_W'(acc_a) + PTR_W'(acc_b);
        rd_d   = rd_q + PTR_W'(pops);

        count_d    = count_q + CNT_W'(acc_a) + CNT_W'(acc_b) - CNT_W'(pops);
        stall_d    = (count_d >= STALL_LVL);
        overflow_d = overflow_q || (execWbA_i && !acc_a) || (execWbB_i && !acc_b);
    end

    // Storage is not reset; validity is tracked entirely by the pointers/count.
    always_ff @(posedge clock_i) begin
        if (acc_a) begin
            addr_mem_q[wr_q]   <= execAddrA_i;
            val_mem_q[wr_q]    <= execValA_i;
            status_mem_q[wr_q] <= execStatusA_i;
        end
        if (acc_b) begin
            addr_mem_q[wr_b]   <= execAddrB_i;
            val_mem_q[wr_b]    <= execValB_i;
            status_mem_q[wr_b] <= execStatusB_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            wbA_q      <= 1'b0;
            wbB_q      <= 1'b0;
            wbAddrA_q  <= '0;
            wbAddrB_q  <= '0;
            wbValA_q   <= '0;
            wbValB_q   <= '0;
            statusA_q  <= '0;
            statusB_q  <= '0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            wbA_q      <= pop_a;
            wbB_q      <= pop_b;
            wbAddrA_q  <= pop_a ? addr_mem_q[rd_q]     : '0;
            wbValA_q   <= pop_a ? val_mem_q[rd_q]      : '0;
            statusA_q  <= pop_a ? status_mem_q[rd_q]   : '0;
            wbAddrB_q  <= pop_b ? addr_mem_q[rd_nxt]   : '0;
            wbValB_q   <= pop_b ? val_mem_q[rd_nxt]    : '0;
            statusB_q  <= pop_b ? status_mem_q[rd_nxt] : '0;
        end
    end

    assign wbA_o              = wbA_q;
    assign wbB_o              = wbB_q;
    assign wbAddrA_o          = wbAddrA_q;
    assign wbAddrB_o          = wbAddrB_q;
    assign wbValA_o           = wbValA_q;
    assign wbValB_o           = wbValB_q;
    assign operationStatusA_o = statusA_q;
    assign operationStatusB_o = statusB_q;
    assign stall_o            = stall_q;
    assign count_o            = count_q;
    assign overflow_o         = overflow_q;

endmodule
`default_nettype wire
